cla_pipe_n: RTL



---
 rtl/cla_pipe_n.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/cla_pipe_n.sv
// -----------------------------------------------------------------------------
// cla_pipe_n : pipelined N-bit carry-lookahead adder.
//
// The N-bit add is cut into K segments of SEG = N/K bits, one per pipeline
// stage. Stage j adds bits [j*SEG +: SEG] with a per-bit generate/propagate
// lookahead chain. The carry-in is ci for stage 0 and the registered carry
// of stage j-1 otherwise. Each stage registers four things:
//   - its segment sum,
//   - its segment carry-out,
//   - the operand bits that later stages have not consumed yet (operand skew),
//   - the sum bits already produced by earlier stages (sum deskew).
// N mod K must be 0. K = 1 is legal.
//
// Optional feature, macro CLA_PIPE_OVF_EN:
//   When defined, port ovf exists and reports two's-complement overflow. It is
//   computed as (carry into bit N-1) XOR co and is aligned with s/co.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous, active-high reset
//   a, b       in   N-bit operands
//   ci         in   carry-in
//   in_valid   in   a/b/ci valid this cycle
//   in_ready   out  pipeline can accept this cycle
//   s          out  N-bit sum
//   co         out  carry-out of bit N-1
//   out_valid  out  s/co hold a valid result
//   ovf        out  signed overflow (only with CLA_PIPE_OVF_EN)
//   out_ready  in   consumer accepts the result this cycle
//
// Handshake: the input transfers when in_valid & in_ready, and the output
// transfers when out_valid & out_ready. The pipeline stalls globally. It
// advances when (!out_valid | out_ready), and in_ready equals that advance
// term, so in_ready depends combinationally on out_ready. While stalled,
// every stage holds. An advance with in_valid=0 inserts a bubble.
// -----------------------------------------------------------------------------
module cla_pipe_n #(
    parameter int N = 16,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] s,
    output logic         co,
    output logic         out_valid,
`ifdef CLA_PIPE_OVF_EN
    output logic         ovf,
`endif
    input  logic         out_ready
);

    localparam int SEG = N / K;

    logic w_adv;

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    for (genvar j = 0; j < K; j++) begin : g_stage
        logic [SEG-1:0]       w_seg_a;
        logic [SEG-1:0]       w_seg_b;
        logic [SEG-1:0]       w_g;
        logic [SEG-1:0]       w_p;
        logic                 w_cin;
        logic                 w_vin;
        logic [SEG:0]         w_c;
        logic [SEG-1:0]       w_sum;
        logic [(j+1)*SEG-1:0] w_s_next;
        logic                 r_v;
        logic                 r_c;
        logic [(j+1)*SEG-1:0] r_s;

        if (j == 0) begin : g_src
            assign w_seg_a  = a[SEG-1:0];
            assign w_seg_b  = b[SEG-1:0];
            assign w_cin    = ci;
            assign w_vin    = in_valid;
            assign w_s_next = w_sum;
        end else begin : g_src
            // This stage consumes the low SEG bits of the skewed operands
            // held by the previous stage.
            assign w_seg_a  = g_stage[j-1].g_ops.r_a[SEG-1:0];
            assign w_seg_b  = g_stage[j-1].g_ops.r_b[SEG-1:0];
            assign w_cin    = g_stage[j-1].r_c;
            assign w_vin    = g_stage[j-1].r_v;
            assign w_s_next = {w_sum, g_stage[j-1].r_s};
        end

        assign w_g = w_seg_a & w_seg_b;
        assign w_p = w_seg_a | w_seg_b;

        always_comb begin
            w_c    = '0;
            w_c[0] = w_cin;
            for (int i = 0; i < SEG; i++) begin
                w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
            end
        end

        assign w_sum = w_seg_a ^ w_seg_b ^ w_c[SEG-1:0];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_v <= 1'b0;
                r_c <= 1'b0;
                r_s <= '0;
            end else if (w_adv) begin
                r_v <= w_vin;
                r_c <= w_c[SEG];
                r_s <= w_s_next;
            end
        end

        // Operand bits above this segment travel along with the add. The
        // last stage has none left to carry.
        if (j < K - 1) begin : g_ops
            localparam int UW = N - (j + 1) * SEG;
            logic [UW-1:0] w_up_a;
            logic [UW-1:0] w_up_b;
            logic [UW-1:0] r_a;
            logic [UW-1:0] r_b;

            if (j == 0) begin : g_up
                assign w_up_a = a[N-1:SEG];
                assign w_up_b = b[N-1:SEG];
            end else begin : g_up
                assign w_up_a = g_stage[j-1].g_ops.r_a[UW+SEG-1:SEG];
                assign w_up_b = g_stage[j-1].g_ops.r_b[UW+SEG-1:SEG];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv) begin
                    r_a <= w_up_a;
                    r_b <= w_up_b;
                end
            end
        end
    end

    assign s         = g_stage[K-1].r_s;
    assign co        = g_stage[K-1].r_c;
    assign out_valid = g_stage[K-1].r_v;

`ifdef CLA_PIPE_OVF_EN
    // Carry into the MSB, captured alongside the final segment.
    logic r_c_msb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_c_msb <= 1'b0;
        end else if (w_adv) begin
            r_c_msb <= g_stage[K-1].w_c[SEG-1];
        end
    end

    assign ovf = r_c_msb ^ co;
`endif

endmodule
